// File: rtl/timer_count_compare_if.sv
// rtl/timer_count_compare_if.sv - register-file bus between the APB register block and the timer counter
interface timer_count_compare_if;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        cnt_lo_we;
  logic        cnt_hi_we;
  logic        cmp_lo_we;
  logic        cmp_hi_we;
  logic        int_st_clr;
  logic [63:0] cnt;
  logic [63:0] cmp;
  logic        int_st;

  modport master (
    output wdata, wstrb, cnt_lo_we, cnt_hi_we, cmp_lo_we, cmp_hi_we, int_st_clr,
    input  cnt, cmp, int_st
  );

  modport slave (
    input  wdata, wstrb, cnt_lo_we, cnt_hi_we, cmp_lo_we, cmp_hi_we, int_st_clr,
    output cnt, cmp, int_st
  );
endinterface

// File: rtl/timer_count_compare.sv
// rtl/timer_count_compare.sv - 64-bit tick counter with compare match and sticky interrupt status
module timer_count_compare (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic count_en,
  input  logic timer_en,
  input  logic halt_req,
  output logic halt_ack,
  input  logic int_en,
  output logic tim_int,
  timer_count_compare_if.slave bus
);

  logic [63:0] cnt_q, cnt_d;
  logic [63:0] cmp_q, cmp_d;
  logic        int_st_q, int_st_d;
  logic        halt_ack_q, halt_ack_d;
  logic        timer_en_prev_q, timer_en_prev_d;
  logic        match;
  logic        disable_edge;

  // Replace only the strobed bytes of a 32-bit half, keeping the rest.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  assign match        = (cnt_q == cmp_q);
  assign disable_edge = timer_en_prev_q & ~timer_en;

  // Counter next value: software write beats disable clear beats tick increment.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_lo_we || bus.cnt_hi_we) begin
      if (bus.cnt_lo_we) cnt_d[31:0]  = byte_merge(cnt_q[31:0],  bus.wdata, bus.wstrb);
      if (bus.cnt_hi_we) cnt_d[63:32] = byte_merge(cnt_q[63:32], bus.wdata, bus.wstrb);
    end else if (disable_edge) begin
      cnt_d = 64'd0;
    end else if (count_en && timer_en && !halt_req) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Compare register writes are independent of counter activity.
  always_comb begin
    cmp_d = cmp_q;
    if (bus.cmp_lo_we) cmp_d[31:0]  = byte_merge(cmp_q[31:0],  bus.wdata, bus.wstrb);
    if (bus.cmp_hi_we) cmp_d[63:32] = byte_merge(cmp_q[63:32], bus.wdata, bus.wstrb);
  end

  // Sticky status: a live match always wins over a write-one-to-clear.
  always_comb begin
    int_st_d        = match | (int_st_q & ~(bus.int_st_clr & bus.wdata[0]));
    halt_ack_d      = halt_req;
    timer_en_prev_d = timer_en;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q           <= 64'd0;
      cmp_q           <= 64'hFFFF_FFFF_FFFF_FFFF;
      int_st_q        <= 1'b0;
      halt_ack_q      <= 1'b0;
      timer_en_prev_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      cmp_q           <= cmp_d;
      int_st_q        <= int_st_d;
      halt_ack_q      <= halt_ack_d;
      timer_en_prev_q <= timer_en_prev_d;
    end
  end

  assign bus.cnt    = cnt_q;
  assign bus.cmp    = cmp_q;
  assign bus.int_st = int_st_q;
  assign halt_ack   = halt_ack_q;
  assign tim_int    = int_st_q & int_en;

endmodule

// File: tb/tb_timer_count_compare.sv
// tb/tb_timer_count_compare.sv - self-checking bench for timer_count_compare
module tb_timer_count_compare;

  logic sys_clk;
  logic sys_rst_n;
  logic count_en, timer_en, halt_req, int_en;
  logic halt_ack, tim_int;

  timer_count_compare_if bus_if();

  timer_count_compare dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .count_en  (count_en),
    .timer_en  (timer_en),
    .halt_req  (halt_req),
    .halt_ack  (halt_ack),
    .int_en    (int_en),
    .tim_int   (tim_int),
    .bus       (bus_if)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        ce;
    logic        te;
    logic        hr;
    logic        ie;
    logic [4:0]  we;   // {cnt_lo, cnt_hi, cmp_lo, cmp_hi, int_st_clr}
    logic [31:0] wd;
    logic [3:0]  st;
    logic [63:0] e_cnt;
    logic        e_ist;
    logic        e_tim;
    logic        e_hack;
  } vec_t;

  vec_t tbl [0:29];

  int pass_cnt = 0;
  int total    = 0;

  // Reference model state
  logic [63:0] m_cnt, m_cmp;
  logic        m_ist, m_hack, m_ten_prev;

  function automatic vec_t mk(input logic ce, te, hr, ie, input logic [4:0] we,
                              input logic [31:0] wd, input logic [3:0] st,
                              input logic [63:0] e_cnt, input logic e_ist, e_tim, e_hack);
    vec_t v;
    v.ce = ce; v.te = te; v.hr = hr; v.ie = ie; v.we = we; v.wd = wd; v.st = st;
    v.e_cnt = e_cnt; v.e_ist = e_ist; v.e_tim = e_tim; v.e_hack = e_hack;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input logic ce, te, hr, ie, input logic [4:0] we,
                       input logic [31:0] wd, input logic [3:0] st);
    count_en = ce; timer_en = te; halt_req = hr; int_en = ie;
    bus_if.cnt_lo_we = we[4]; bus_if.cnt_hi_we = we[3];
    bus_if.cmp_lo_we = we[2]; bus_if.cmp_hi_we = we[1];
    bus_if.int_st_clr = we[0];
    bus_if.wdata = wd; bus_if.wstrb = st;
  endtask

  task automatic step(input logic ce, te, hr, ie, input logic [4:0] we,
                      input logic [31:0] wd, input logic [3:0] st);
    drive(ce, te, hr, ie, we, wd, st);
    @(posedge sys_clk);
    #1;
  endtask

  // Spec-level next state: writes, then disable clear, then tick; set beats clear.
  task automatic model_next(input logic ce, te, hr, input logic [4:0] we,
                            input logic [31:0] wd, input logic [3:0] st);
    logic [63:0] n_cnt, n_cmp;
    logic        hit;
    hit   = (m_cnt == m_cmp);
    n_cnt = m_cnt;
    n_cmp = m_cmp;
    if (we[4] || we[3]) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b] && we[4]) n_cnt[8*b +: 8]      = wd[8*b +: 8];
        if (st[b] && we[3]) n_cnt[32 + 8*b +: 8] = wd[8*b +: 8];
      end
    end else if (m_ten_prev && !te) begin
      n_cnt = 0;
    end else if (ce && te && !hr) begin
      n_cnt = m_cnt + 1;
    end
    for (int b = 0; b < 4; b++) begin
      if (st[b] && we[2]) n_cmp[8*b +: 8]      = wd[8*b +: 8];
      if (st[b] && we[1]) n_cmp[32 + 8*b +: 8] = wd[8*b +: 8];
    end
    m_ist      = hit || (m_ist && !(we[0] && wd[0]));
    m_cnt      = n_cnt;
    m_cmp      = n_cmp;
    m_hack     = hr;
    m_ten_prev = te;
  endtask

  initial begin
    logic        r_ce, r_te, r_hr, r_ie;
    logic [4:0]  r_we;
    logic [31:0] r_wd;
    logic [3:0]  r_st;

    // Directed table following the bring-up scenario
    for (int i = 0; i < 5; i++) tbl[i] = mk(1,1,0,0,5'b00000,0,0, 64'(i+1),0,0,0);
    tbl[5]  = mk(1,1,0,0,5'b10000,32'hAA,4'h1, 64'hAA,0,0,0);
    tbl[6]  = mk(0,1,0,0,5'b10000,0,4'hF, 0,0,0,0);
    tbl[7]  = mk(0,1,0,0,5'b00010,0,4'hF, 0,0,0,0);
    tbl[8]  = mk(0,1,0,0,5'b00100,3,4'hF, 0,0,0,0);
    tbl[9]  = mk(1,1,0,1,5'b00000,0,0, 1,0,0,0);
    tbl[10] = mk(1,1,0,1,5'b00000,0,0, 2,0,0,0);
    tbl[11] = mk(1,1,0,1,5'b00000,0,0, 3,0,0,0);
    tbl[12] = mk(0,1,0,1,5'b00000,0,0, 3,1,1,0);
    tbl[13] = mk(0,1,0,1,5'b00001,1,4'hF, 3,1,1,0);
    tbl[14] = mk(1,1,0,1,5'b00000,0,0, 4,1,1,0);
    tbl[15] = mk(0,1,0,1,5'b00001,1,4'hF, 4,0,0,0);
    tbl[16] = mk(0,1,0,1,5'b10000,20,4'hF, 20,0,0,0);
    tbl[17] = mk(1,0,0,1,5'b00000,0,0, 0,0,0,0);
    tbl[18] = mk(1,1,0,1,5'b00000,0,0, 1,0,0,0);
    tbl[19] = mk(1,1,0,1,5'b00000,0,0, 2,0,0,0);
    tbl[20] = mk(1,1,0,1,5'b00000,0,0, 3,0,0,0);
    tbl[21] = mk(1,1,0,1,5'b00000,0,0, 4,1,1,0);
    tbl[22] = mk(1,1,0,1,5'b00000,0,0, 5,1,1,0);
    tbl[23] = mk(1,1,0,1,5'b00000,0,0, 6,1,1,0);
    tbl[24] = mk(1,1,0,1,5'b00000,0,0, 7,1,1,0);
    for (int i = 25; i < 29; i++) tbl[i] = mk(1,1,1,1,5'b00000,0,0, 7,1,1,1);
    tbl[29] = mk(1,1,0,1,5'b00000,0,0, 8,1,1,0);

    sys_rst_n = 1'b0;
    drive(0,0,0,0,5'b00000,0,0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    chk("reset_cnt", bus_if.cnt, 64'd0);
    chk("reset_cmp", bus_if.cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("reset_int_st", {63'd0, bus_if.int_st}, 64'd0);
    chk("reset_halt_ack", {63'd0, halt_ack}, 64'd0);
    chk("reset_tim_int", {63'd0, tim_int}, 64'd0);

    for (int i = 0; i < 30; i++) begin
      step(tbl[i].ce, tbl[i].te, tbl[i].hr, tbl[i].ie, tbl[i].we, tbl[i].wd, tbl[i].st);
      chk($sformatf("tbl%0d_cnt", i), bus_if.cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_int_st", i), {63'd0, bus_if.int_st}, {63'd0, tbl[i].e_ist});
      chk($sformatf("tbl%0d_tim_int", i), {63'd0, tim_int}, {63'd0, tbl[i].e_tim});
      chk($sformatf("tbl%0d_halt_ack", i), {63'd0, halt_ack}, {63'd0, tbl[i].e_hack});
      if (i == 4) chk("cmp_untouched", bus_if.cmp, 64'hFFFF_FFFF_FFFF_FFFF);
      if (i == 8) chk("cmp_is_3", bus_if.cmp, 64'd3);
    end

    // Async reset mid-count with status set
    step(1,1,0,1,5'b00000,0,0);
    chk("pre_reset_cnt", bus_if.cnt, 64'd9);
    chk("pre_reset_int_st", {63'd0, bus_if.int_st}, 64'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_cnt", bus_if.cnt, 64'd0);
    chk("async_int_st", {63'd0, bus_if.int_st}, 64'd0);
    chk("async_tim_int", {63'd0, tim_int}, 64'd0);
    chk("async_cmp", bus_if.cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    step(1,1,0,1,5'b00000,0,0);
    chk("first_count_after_reset", bus_if.cnt, 64'd1);

    // Carry from bit 31 into bit 32, then full wrap
    step(0,1,0,1,5'b10000,32'hFFFF_FFFF,4'hF);
    step(0,1,0,1,5'b01000,32'h0,4'hF);
    chk("carry_preset", bus_if.cnt, 64'h0000_0000_FFFF_FFFF);
    step(1,1,0,1,5'b00000,0,0);
    chk("carry_cnt", bus_if.cnt, 64'h0000_0001_0000_0000);
    step(0,1,0,1,5'b11000,32'hFFFF_FFFF,4'hF);
    chk("ones_preset", bus_if.cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1,1,0,1,5'b00000,0,0);
    chk("wrap_cnt", bus_if.cnt, 64'd0);
    chk("wrap_int_st", {63'd0, bus_if.int_st}, 64'd1);
    chk("wrap_tim_int", {63'd0, tim_int}, 64'd1);

    // Randomized run against the reference model
    drive(0,0,0,0,5'b00000,0,0);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    m_cnt = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_ist = 0; m_hack = 0; m_ten_prev = 0;

    for (int n = 0; n < 400; n++) begin
      r_ce = ($urandom_range(0, 1) == 1);
      r_te = ($urandom_range(0, 9) != 0);
      r_hr = ($urandom_range(0, 9) == 0);
      r_ie = ($urandom_range(0, 3) != 0);
      r_we[4] = ($urandom_range(0, 19) == 0);
      r_we[3] = ($urandom_range(0, 29) == 0);
      r_we[2] = ($urandom_range(0, 14) == 0);
      r_we[1] = ($urandom_range(0, 29) == 0);
      r_we[0] = ($urandom_range(0, 7) == 0);
      r_wd = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
      r_st = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      model_next(r_ce, r_te, r_hr, r_we, r_wd, r_st);
      step(r_ce, r_te, r_hr, r_ie, r_we, r_wd, r_st);
      chk($sformatf("rnd%0d_cnt", n), bus_if.cnt, m_cnt);
      chk($sformatf("rnd%0d_cmp", n), bus_if.cmp, m_cmp);
      chk($sformatf("rnd%0d_int_st", n), {63'd0, bus_if.int_st}, {63'd0, m_ist});
      chk($sformatf("rnd%0d_tim_int", n), {63'd0, tim_int}, {63'd0, m_ist & r_ie});
      chk($sformatf("rnd%0d_halt_ack", n), {63'd0, halt_ack}, {63'd0, m_hack});
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/timer_count_compare.md
# timer_count_compare

64-bit up-counter with compare and interrupt generation for the timer IP. Consumes the single-cycle `count_en` tick from the prescaler/control stage and advances the count on each tick. Raises a sticky interrupt status when the count equals a software-programmed 64-bit compare value. Sits between the prescaler and the APB register file, which supplies write strobes and data and reads back `cnt`, `cmp` and `int_st`.

## Interface
- No parameters; widths are fixed.
- sys_clk  in  1  clock; all state updates on the rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- count_en  in  1  increment tick from the prescaler; one count per high cycle.
- timer_en  in  1  timer enable (register-file bit); a 1->0 transition clears the counter.
- halt_req  in  1  debug halt request; freezes the counter while high.
- halt_ack  out  1  registered copy of halt_req.
- wdata  in  32  register write data.
- wstrb  in  4  byte strobes for wdata; byte n is written only if wstrb[n]=1.
- cnt_lo_we / cnt_hi_we  in  1 each  write pulse to cnt[31:0] / cnt[63:32].
- cmp_lo_we / cmp_hi_we  in  1 each  write pulse to cmp[31:0] / cmp[63:32].
- int_st_clr  in  1  W1C pulse for the status register; clears only if wdata[0]=1.
- int_en  in  1  interrupt enable.
- cnt  out  64  current count.
- cmp  out  64  compare value.
- int_st  out  1  sticky match status.
- tim_int  out  1  interrupt output, int_st & int_en; combinational from registered int_st.

## Operation
- Reset values:
  - cnt = 0
  - cmp = 64'hFFFF_FFFF_FFFF_FFFF
  - int_st = 0
  - halt_ack = 0
  - internal timer_en_d = 0
- Counter update priority, highest first, evaluated each edge:
  1. Software write: any of cnt_lo_we / cnt_hi_we high. The addressed half takes the wdata bytes selected by wstrb; unselected bytes and the other half hold. No increment occurs in that cycle.
  2. Disable clear: timer_en_d=1 and timer_en=0. cnt becomes 0.
  3. Increment: count_en=1, timer_en=1 and halt_req=0. cnt becomes cnt+1.
  4. Otherwise cnt holds.
- cnt_lo_we and cnt_hi_we in the same cycle: both halves are written.
- Arithmetic: full 64-bit add with carry from bit 31 into bit 32. At 64'hFFFF_FFFF_FFFF_FFFF, an increment wraps to 0. No overflow flag.
- Compare writes: byte-masked per wstrb, independent of all counter activity. Both halves may be written in one cycle.
- Match: match = (cnt == cmp), combinational on registered values. It is evaluated regardless of timer_en, so a stopped counter sitting on cmp keeps match=1.
- Status register:
  - next int_st = match | (int_st & ~(int_st_clr & wdata[0])).
  - Set wins over clear. A clear while match=1 leaves int_st=1.
- halt_ack <= halt_req. The freeze itself uses halt_req directly.
- timer_en_d <= timer_en every cycle.

## Timing
- count_en high at edge N: cnt shows the new value after edge N (zero-latency consumption of the tick).
- cnt becomes equal to cmp after edge N: match is high during cycle N+1, and int_st/tim_int rise after edge N+1 (one-cycle latency).
- Software cnt write at edge N: the new value is visible after N. If that value equals cmp, int_st rises after N+1.
- timer_en falls (sampled 0 at edge N while timer_en_d=1): cnt=0 after N. A count_en at edge N is ignored.
- timer_en rises: no clear. Counting resumes on the first count_en sampled with timer_en=1.
- Reset asserted mid-count: all state returns to reset values asynchronously. The first count is possible at the first edge after deassertion.
- halt_req high at edge N: no increment at N. Ticks arriving during halt are discarded, not accumulated.

## Test plan
- Reset, then count_en held high with timer_en=1 for 5 cycles -> cnt=5, int_st=0, cmp=64'hFFFF_FFFF_FFFF_FFFF.
- Carry propagation: write cnt_lo=32'hFFFF_FFFF and cnt_hi=0 (wstrb=4'hF), then one tick -> cnt=64'h0000_0001_0000_0000. Preset cnt to all-ones, then one tick -> cnt=0.
- Compare and interrupt:
  - cmp=3, int_en=1, count_en continuous: cnt reaches 3, then tim_int=1 one cycle later.
  - int_st_clr with wdata[0]=1 while cnt=3 and frozen -> int_st stays 1.
  - Advance cnt to 4, then clear -> int_st=0 and tim_int=0.
- Priority: in one cycle, cnt_lo_we=1, wdata=32'h0000_00AA, wstrb=4'h1, count_en=1 with old cnt=5 -> cnt=64'h0000_0000_0000_00AA, no increment applied.
- Disable and halt:
  - cnt=20, drop timer_en -> cnt=0 after the next edge.
  - Re-enable, count to 7, assert halt_req for 4 ticks -> cnt stays 7 and halt_ack=1 one cycle after halt_req.
  - Release halt_req -> counting resumes from 7.
- Async reset mid-count at cnt=9 with int_st=1 -> cnt=0, int_st=0, tim_int=0 immediately, without a clock edge.
